// File: rtl/reg_bank_if.sv
// Strobe/data bundle between the register-select unit and reg_bank.
// REG_BANK_SP_EN adds the stack-pointer step strobes sp_inc/sp_dec.
interface reg_bank_if #(
  parameter int unsigned WIDTH = 16
);
  logic [7:0]       regOes;
  logic [7:0]       regLoads;
  logic [WIDTH-1:0] bus_in;
  logic             pc_inc;
  logic             err_clr;
`ifdef REG_BANK_SP_EN
  logic             sp_inc;
  logic             sp_dec;
`endif
  logic [WIDTH-1:0] bus_out;
  logic             bus_oe;
  logic [WIDTH-1:0] pc;
  logic             err_oe;
  logic             err_load;

  modport master (
`ifdef REG_BANK_SP_EN
    output sp_inc, sp_dec,
`endif
    output regOes, regLoads, bus_in, pc_inc, err_clr,
    input  bus_out, bus_oe, pc, err_oe, err_load
  );

  modport slave (
`ifdef REG_BANK_SP_EN
    input  sp_inc, sp_dec,
`endif
    input  regOes, regLoads, bus_in, pc_inc, err_clr,
    output bus_out, bus_oe, pc, err_oe, err_load
  );
endinterface

// File: rtl/reg_bank.sv
// Eight-entry register file driven by one-hot oe/load strobes; r7 is the PC.
// Define REG_BANK_SP_EN to make r6 a stack pointer with sp_inc/sp_dec steps.
module reg_bank #(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input logic        clk,
  input logic        reset_n,
  reg_bank_if.slave  bus
);

  localparam int unsigned NumRegs = 8;

  logic [WIDTH-1:0] r_regs     [NumRegs];
  logic [WIDTH-1:0] w_regs_nxt [NumRegs];
  logic             r_err_oe;
  logic             r_err_load;

  logic w_oe_multi;
  logic w_oe_one;
  logic w_ld_multi;
  logic w_ld_one;
  logic w_sp_conflict;

  // x & (x-1) is nonzero exactly when more than one bit is set.
  assign w_oe_multi = |(bus.regOes & (bus.regOes - 8'd1));
  assign w_oe_one   = (bus.regOes != 8'd0) && !w_oe_multi;
  assign w_ld_multi = |(bus.regLoads & (bus.regLoads - 8'd1));
  assign w_ld_one   = (bus.regLoads != 8'd0) && !w_ld_multi;

  always_comb begin
    bus.bus_out = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (w_oe_one && bus.regOes[i]) begin
        bus.bus_out = bus.bus_out | r_regs[i];
      end
    end
  end

  assign bus.bus_oe   = w_oe_one;
  assign bus.pc       = r_regs[7];
  assign bus.err_oe   = r_err_oe;
  assign bus.err_load = r_err_load;

  always_comb begin
    w_sp_conflict = 1'b0;
    for (int i = 0; i < NumRegs; i++) begin
      w_regs_nxt[i] = (w_ld_one && bus.regLoads[i]) ? bus.bus_in : r_regs[i];
    end
    // A legal load of r7 overrides the increment; a multi-hot load does not.
    if (bus.pc_inc && !(w_ld_one && bus.regLoads[7])) begin
      w_regs_nxt[7] = r_regs[7] + WIDTH'(1);
    end
`ifdef REG_BANK_SP_EN
    if (!(w_ld_one && bus.regLoads[6])) begin
      if (bus.sp_inc && bus.sp_dec) begin
        w_sp_conflict = 1'b1;
      end else if (bus.sp_inc) begin
        w_regs_nxt[6] = r_regs[6] + WIDTH'(1);
      end else if (bus.sp_dec) begin
        w_regs_nxt[6] = r_regs[6] - WIDTH'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NumRegs - 1; i++) begin
        r_regs[i] <= '0;
      end
      r_regs[7]  <= PC_RESET;
      r_err_oe   <= 1'b0;
      r_err_load <= 1'b0;
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i] <= w_regs_nxt[i];
      end
      // A new violation on the clear edge keeps the flag set.
      r_err_oe   <= w_oe_multi | (r_err_oe & ~bus.err_clr);
      r_err_load <= w_ld_multi | w_sp_conflict | (r_err_load & ~bus.err_clr);
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: a popcount-based reference model checked every negedge,
// plus directed vectors with literal expectations.
module tb_reg_bank;

  localparam int unsigned W      = 16;
  localparam logic [15:0] PC_RST = 16'h0000;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  always #20 clk = ~clk;

  reg_bank_if #(.WIDTH(W)) u_if ();

  reg_bank #(
    .WIDTH   (W),
    .PC_RESET(PC_RST)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (u_if)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents and sticky flags.
  logic [W-1:0] m_regs [8];
  logic         m_err_oe;
  logic         m_err_ld;

  always @(posedge clk or negedge reset_n) begin : model
    logic [W-1:0] nxt [8];
    int           nl;
    bit           conflict;
    if (!reset_n) begin
      for (int i = 0; i < 7; i++) m_regs[i] <= '0;
      m_regs[7] <= PC_RST;
      m_err_oe  <= 1'b0;
      m_err_ld  <= 1'b0;
    end else begin
      nxt      = m_regs;
      conflict = 1'b0;
      nl       = $countones(u_if.regLoads);
      if (nl == 1) nxt[$clog2(u_if.regLoads)] = u_if.bus_in;
      if (u_if.pc_inc && !(nl == 1 && u_if.regLoads == 8'h80)) nxt[7] = m_regs[7] + 16'd1;
`ifdef REG_BANK_SP_EN
      if (!(nl == 1 && u_if.regLoads == 8'h40)) begin
        if (u_if.sp_inc && u_if.sp_dec) conflict = 1'b1;
        else if (u_if.sp_inc) nxt[6] = m_regs[6] + 16'd1;
        else if (u_if.sp_dec) nxt[6] = m_regs[6] - 16'd1;
      end
`endif
      m_regs   <= nxt;
      m_err_oe <= ($countones(u_if.regOes) > 1) || (m_err_oe && !u_if.err_clr);
      m_err_ld <= (nl > 1) || conflict || (m_err_ld && !u_if.err_clr);
    end
  end

  always @(negedge clk) begin : compare
    logic [W-1:0] exp_out;
    logic         exp_oe;
    if (reset_n) begin
      exp_oe  = ($countones(u_if.regOes) == 1);
      exp_out = exp_oe ? m_regs[$clog2(u_if.regOes)] : '0;
      chk("model bus_out", u_if.bus_out, exp_out);
      chk("model bus_oe", u_if.bus_oe, exp_oe);
      chk("model pc", u_if.pc, m_regs[7]);
      chk("model err_oe", u_if.err_oe, m_err_oe);
      chk("model err_load", u_if.err_load, m_err_ld);
    end
  end

  // Inputs change 1 ns after the rising edge and are captured on the next one.
  task automatic drive(input logic [7:0] oes, input logic [7:0] loads, input logic [15:0] din,
                       input logic inc, input logic clr);
    @(posedge clk);
    #1;
    u_if.regOes   = oes;
    u_if.regLoads = loads;
    u_if.bus_in   = din;
    u_if.pc_inc   = inc;
    u_if.err_clr  = clr;
`ifdef REG_BANK_SP_EN
    u_if.sp_inc = 1'b0;
    u_if.sp_dec = 1'b0;
`endif
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    u_if.regOes   = '0;
    u_if.regLoads = '0;
    u_if.bus_in   = '0;
    u_if.pc_inc   = 1'b0;
    u_if.err_clr  = 1'b0;
`ifdef REG_BANK_SP_EN
    u_if.sp_inc = 1'b0;
    u_if.sp_dec = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #5 reset_n = 1'b1;

    // Reset state.
    drive(8'h80, 8'h00, 16'h0, 1'b0, 1'b0);
    #4;
    chk("reset pc", u_if.pc, 16'h0000);
    chk("reset bus_out r7", u_if.bus_out, PC_RST);
    chk("reset bus_oe", u_if.bus_oe, 1'b1);
    chk("reset err_oe", u_if.err_oe, 1'b0);
    chk("reset err_load", u_if.err_load, 1'b0);

    // Load and read back every register.
    for (int i = 0; i < 8; i++) drive(8'h00, 8'(1 << i), 16'hA000 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(8'(1 << i), 8'h00, 16'h0, 1'b0, 1'b0);
      #4;
      chk("readback", u_if.bus_out, 16'hA000 + 16'(i));
      chk("readback oe", u_if.bus_oe, 1'b1);
    end
    drive(8'h08, 8'h08, 16'hBEEF, 1'b0, 1'b0);
    #4 chk("r3 read during write", u_if.bus_out, 16'hA003);
    drive(8'h08, 8'h00, 16'h0, 1'b0, 1'b0);
    #4 chk("r3 after write", u_if.bus_out, 16'hBEEF);

    // PC wrap and load-over-increment.
    drive(8'h00, 8'h80, 16'hFFFF, 1'b0, 1'b0);
    drive(8'h00, 8'h00, 16'h0, 1'b1, 1'b0);
    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b0);
    #4 chk("pc wrap", u_if.pc, 16'h0000);
    drive(8'h00, 8'h80, 16'h1234, 1'b1, 1'b0);
    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b0);
    #4 chk("pc load wins", u_if.pc, 16'h1234);
    drive(8'h00, 8'h03, 16'h0, 1'b1, 1'b0);
    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b0);
    #4 chk("pc inc with multi-hot load", u_if.pc, 16'h1235);

    // Illegal strobes and sticky flags.
    drive(8'h00, 8'h03, 16'hDEAD, 1'b0, 1'b0);
    drive(8'h01, 8'h00, 16'h0, 1'b0, 1'b0);
    #4;
    chk("r0 unchanged", u_if.bus_out, 16'hA000);
    chk("err_load set", u_if.err_load, 1'b1);
    drive(8'h02, 8'h00, 16'h0, 1'b0, 1'b0);
    #4;
    chk("r1 unchanged", u_if.bus_out, 16'hA001);
    chk("err_load held", u_if.err_load, 1'b1);
    drive(8'h05, 8'h00, 16'h0, 1'b0, 1'b0);
    #4;
    chk("multi oe bus_out", u_if.bus_out, 16'h0000);
    chk("multi oe bus_oe", u_if.bus_oe, 1'b0);
    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b0);
    #4 chk("err_oe set", u_if.err_oe, 1'b1);
    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b1);
    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b0);
    #4;
    chk("err_oe cleared", u_if.err_oe, 1'b0);
    chk("err_load cleared", u_if.err_load, 1'b0);
    drive(8'h11, 8'h00, 16'h0, 1'b0, 1'b1);
    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b0);
    #4 chk("set beats clear", u_if.err_oe, 1'b1);

    // Asynchronous reset mid-cycle discards the pending load and increment.
    drive(8'h00, 8'h04, 16'h5555, 1'b1, 1'b0);
    #1 reset_n = 1'b0;
    #1 chk("async reset pc", u_if.pc, PC_RST);
    chk("async reset err_oe", u_if.err_oe, 1'b0);
    for (int i = 0; i < 8; i++) begin
      u_if.regOes = 8'(1 << i);
      #1 chk("async reset reg", u_if.bus_out, (i == 7) ? PC_RST : 16'h0000);
    end
    u_if.regOes   = '0;
    u_if.regLoads = '0;
    u_if.pc_inc   = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    drive(8'h04, 8'h00, 16'h0, 1'b0, 1'b0);
    #4;
    chk("r2 write lost", u_if.bus_out, 16'h0000);
    chk("pc after reset", u_if.pc, PC_RST);

`ifdef REG_BANK_SP_EN
    drive(8'h40, 8'h00, 16'h0, 1'b0, 1'b0);
    #4 chk("sp start", u_if.bus_out, 16'h0000);
    u_if.sp_dec = 1'b1;
    drive(8'h40, 8'h00, 16'h0, 1'b0, 1'b0);
    #4 chk("sp dec wrap", u_if.bus_out, 16'hFFFF);
    u_if.sp_inc = 1'b1;
    drive(8'h40, 8'h40, 16'h0100, 1'b0, 1'b0);
    #4 chk("sp inc wrap", u_if.bus_out, 16'h0000);
    u_if.sp_inc = 1'b1;
    drive(8'h40, 8'h00, 16'h0, 1'b0, 1'b0);
    #4 chk("sp load wins", u_if.bus_out, 16'h0100);
    u_if.sp_inc = 1'b1;
    u_if.sp_dec = 1'b1;
    drive(8'h40, 8'h00, 16'h0, 1'b0, 1'b0);
    #4;
    chk("sp conflict no change", u_if.bus_out, 16'h0100);
    chk("sp conflict err_load", u_if.err_load, 1'b1);
`endif

    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
